alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered result stage that sits directly downstream of the 32-bit carry-skip adder.
- Captures the adder sum and carry-out together with the operand sign context.
- Computes the status flags: carry/borrow, zero, negative and signed overflow.
- Buffers results in a small FIFO with valid/ready handshakes on both sides, decoupling the combinational adder from the consuming pipeline stage.

Parameters:
- M, 32: datapath width; must be a multiple of 4, matching the adder width.
- DEPTH, 2: result FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  adder result and context are valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- in_a  input  M  operand A as presented to the adder (sign bit used for overflow).
- in_b  input  M  operand B before any inversion (sign bit used for overflow).
- in_sub  input  1  0 = A+B with Cin=0; 1 = A-B, meaning the adder saw ~B with Cin=1.
- in_sum  input  M  adder S output.
- in_cout  input  1  adder Cout output.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  M  registered sum.
- out_carry  output  1  carry for add; borrow (~in_cout) for sub.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[M-1].
- out_ovf  output  1  signed overflow.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, while rst=1):
  - FIFO empty; level=0; out_valid=0.
  - out_result=0; out_carry, out_zero, out_neg and out_ovf all 0.
  - Read/write pointers = 0.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (level != DEPTH). It is combinational from registered state only, with no path from out_ready.
  - in_valid may be held high with in_ready low; nothing is captured until in_ready=1.
- Flag computation is combinational on the inputs and stored alongside the sum at push:
  - add: ovf = (a[M-1]==b[M-1]) & (sum[M-1]!=a[M-1]); carry = cout.
  - sub: ovf = (a[M-1]!=b[M-1]) & (sum[M-1]!=a[M-1]); carry = ~cout.
  - zero = ~|sum; neg = sum[M-1].
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N (earliest cycle N+1). The FIFO has no fall-through.
- Output data:
  - out_* show the head entry whenever out_valid=1.
  - When empty, out_* hold the last popped values. The bench must not check them while out_valid=0.
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1; level is unchanged.
  - When level==DEPTH, in_ready=0, so a pop frees the slot and the push is taken on the following cycle.
  - When level==0, a push and a pop in the same cycle cannot occur, because out_valid=0.
- Full: level==DEPTH gives in_ready=0. Input is ignored and no entry is overwritten.
- Empty: level==0 gives out_valid=0, and out_ready is ignored.
- Reset mid-operation: all entries are discarded immediately and outputs return to their reset values. There is no partial state on release.
- Assertions (bench):
  - level never exceeds DEPTH.
  - out_* stable while out_valid & ~out_ready.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- Defined:
  - Adds port sticky_clr (input, 1) and port ovf_sticky (output, 1).
  - ovf_sticky resets to 0.
  - ovf_sticky is set on any pop whose entry has ovf=1.
  - It is cleared when sticky_clr=1, unless a set occurs in the same cycle; set wins.
- Undefined: both ports and the register are absent; all other behaviour is identical.

Test Plan:
- Add 0x7FFFFFFF+0x00000001 (sum 0x80000000, cout 0), out_ready=1 → one cycle later out_valid=1, result 0x80000000, ovf=1, neg=1, carry=0, zero=0.
- Sub 0x00000005-0x00000005 (sum 0, cout 1) → zero=1, carry(borrow)=0, ovf=0. Then sub 3-5 (sum 0xFFFFFFFE, cout 0) → borrow=1, neg=1, ovf=0.
- out_ready=0, push 3 entries back-to-back (DEPTH=2) → in_ready=0 after the 2nd push, level=2, 3rd held. Release out_ready → entries popped in order 1,2,3 with no loss or duplication.
- Continuous in_valid and out_ready=1 for 100 random add/sub → one result per cycle after first, flags match reference model; level toggles between 0 and 1 only.
- Assert rst with level=2 mid-stream → out_valid=0 and level=0 immediately (asynchronous). After release, the first new push appears correctly.
- With ALU_STICKY_OVF_EN: pop one overflow entry → ovf_sticky=1. sticky_clr=1 together with another overflow pop → stays 1. Then sticky_clr=1 alone → 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage behind the carry-skip adder: computes status flags and buffers them in a FIFO.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow flag (sticky_clr / ovf_sticky).
module alu_result_stage #(
  parameter int M     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [M-1:0]             in_a,
  input  logic [M-1:0]             in_b,
  input  logic                     in_sub,
  input  logic [M-1:0]             in_sum,
  input  logic                     in_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M-1:0]             out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
`ifdef ALU_STICKY_OVF_EN
  input  logic                     sticky_clr,
  output logic                     ovf_sticky,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [$clog2(DEPTH):0] FULL = ($clog2(DEPTH)+1)'(DEPTH);

  typedef struct packed {
    logic [M-1:0] result;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_ent, head, last_q;
  logic [AW-1:0]      wptr, rptr;
  logic               push, pop;

  // Only the operand sign bits feed the overflow logic.
  logic unused_opbits;
  assign unused_opbits = ^{in_a[M-2:0], in_b[M-2:0]};

  // Subtract means the adder saw ~B, so B's effective sign is inverted.
  always_comb begin
    wr_ent        = '0;
    wr_ent.result = in_sum;
    wr_ent.carry  = in_sub ? ~in_cout : in_cout;
    wr_ent.zero   = ~|in_sum;
    wr_ent.neg    = in_sum[M-1];
    wr_ent.ovf    = ((in_a[M-1] ^ in_sub) == in_b[M-1]) & (in_sum[M-1] != in_a[M-1]);
  end

  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                           mem[gi] <= '0;
        else if (push && wptr == AW'(gi))  mem[gi] <= wr_ent;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Holds the last popped entry so outputs stay put while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_q <= '0;
    else if (pop) last_q <= head;
  end

  assign head       = mem[rptr];
  assign out_result = out_valid ? head.result : last_q.result;
  assign out_carry  = out_valid ? head.carry  : last_q.carry;
  assign out_zero   = out_valid ? head.zero   : last_q.zero;
  assign out_neg    = out_valid ? head.neg    : last_q.neg;
  assign out_ovf    = out_valid ? head.ovf    : last_q.ovf;

`ifdef ALU_STICKY_OVF_EN
  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ovf_sticky <= 1'b0;
    else if (pop & head.ovf) ovf_sticky <= 1'b1;
    else if (sticky_clr)     ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: random add/sub against a signed/unsigned arithmetic model.
module tb_alu_result_stage;
  localparam int M = 32;
  localparam int DEPTH = 2;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sub = 0, in_cout = 0;
  logic [M-1:0] in_a = 0, in_b = 0, in_sum = 0;
  logic out_valid, out_ready = 0;
  logic [M-1:0] out_result;
  logic out_carry, out_zero, out_neg, out_ovf;
  logic [$clog2(DEPTH):0] level;
`ifdef ALU_STICKY_OVF_EN
  logic sticky_clr = 0, ovf_sticky;
`endif

  alu_result_stage #(.M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
`ifdef ALU_STICKY_OVF_EN
    .sticky_clr(sticky_clr), .ovf_sticky(ovf_sticky),
`endif
    .level(level));

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] res;
    logic carry, zero, neg, ovf;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  bit rnd_phase = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands.
  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b, input logic sub);
    exp_t e;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    ua = {32'd0, a}; ub = {32'd0, b};
    sa = longint'($signed(a)); sb = longint'($signed(b));
    sr = sub ? sa - sb : sa + sb;
    e.res   = sub ? a - b : a + b;
    e.carry = sub ? (ua < ub) : ((ua + ub) > 64'hFFFF_FFFF);
    e.zero  = (e.res == 0);
    e.neg   = ($signed(e.res) < 0);
    e.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  // Drives the adder outputs the way the upstream adder would.
  task automatic send(input logic [M-1:0] a, input logic [M-1:0] b, input logic sub);
    logic [M:0] full;
    int t = 0;
    full = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    in_valid = 1; in_a = a; in_b = b; in_sub = sub;
    in_sum = full[M-1:0]; in_cout = full[M];
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Monitor: pops the scoreboard on each handshake, then records pushes.
  logic prev_hold = 0;
  logic [M+3:0] prev_out;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_hold = 0;
    else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_result, out_carry, out_zero, out_neg, out_ovf}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", out_result, e.res);
          chk("carry", out_carry, e.carry);
          chk("zero", out_zero, e.zero);
          chk("neg", out_neg, e.neg);
          chk("ovf", out_ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
      if (level > DEPTH) chk("level_le_depth", level, DEPTH);
      if (rnd_phase && level > 1) chk("rnd_level_le1", level, 1);
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_result, out_carry, out_zero, out_neg, out_ovf};
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {out_result, out_carry, out_zero, out_neg, out_ovf}, 0);
`ifdef ALU_STICKY_OVF_EN
    chk("rst_sticky", ovf_sticky, 0);
`endif
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Overflowing add, visible the cycle after the push
    out_ready = 0;
    send(32'h7FFF_FFFF, 32'h1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 32'h8000_0000);
    chk("t1_flags", {out_carry, out_zero, out_neg, out_ovf}, 4'b0011);
    out_ready = 1;
    @(posedge clk); #1;

    // Subtract edge cases
    send(32'd5, 32'd5, 1);
    send(32'd3, 32'd5, 1);
    @(posedge clk); #1;

    // Fill the FIFO, third entry held off
    out_ready = 0;
    fork
      begin send(32'd1, 32'd0, 0); send(32'd2, 32'd0, 0); send(32'd3, 32'd0, 0); end
      begin
        repeat (4) @(negedge clk);
        chk("full_level", level, DEPTH);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Streaming random add/sub
    rnd_phase = 1;
    for (int i = 0; i < 100; i++) begin
      logic [M-1:0] a, b;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = a;
        default: ;
      endcase
      send(a, b, 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk); #1;
    rnd_phase = 0;

    // Asynchronous reset with a full FIFO
    out_ready = 0;
    send(32'd10, 32'd1, 0);
    send(32'd20, 32'd1, 1);
    chk("pre_rst_level", level, 2);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_result", out_result, 0);
    exp_q.delete();
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    send(32'hFFFF_FFFF, 32'h1, 0);
    @(posedge clk); #1;

`ifdef ALU_STICKY_OVF_EN
    out_ready = 0;
    chk("sticky_clear_after_rst", ovf_sticky, 0);
    send(32'h7FFF_FFFF, 32'h1, 0);
    send(32'h8000_0000, 32'h1, 1);
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    chk("sticky_set", ovf_sticky, 1);
    sticky_clr = 1; out_ready = 1; @(posedge clk); #1; out_ready = 0;
    chk("sticky_set_wins", ovf_sticky, 1);
    @(posedge clk); #1; sticky_clr = 0;
    chk("sticky_cleared", ovf_sticky, 0);
    out_ready = 1;
`endif

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin @(posedge clk); t++; end
      chk("drain_remaining", exp_q.size(), 0);
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
